// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, default oversampling and frame shape.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int OSR_DEF       = 16;
  localparam int DATA_BITS_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad; resets to the idle line level.
// Latency: 2 txclk.
// Backpressure: none.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic txclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      meta <= LINE_IDLE;
      q    <= LINE_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver feeding a load/unload holding register with status flags.
// Latency: byte lands 3 + OSR/2 + (DATA_BITS+1)*OSR txclk after the start-bit falling edge.
// Backpressure: none on rx_in; a byte completing while the holding register is full is dropped and flags overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OSR       = OSR_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 txclk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_over_run,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int SW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [SW-1:0] HALF_M1  = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OSR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state, state_nxt;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 start_hit, bit_hit, stop_hit;

  uart_rx_sync u_sync (
    .txclk (txclk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!rx_enable) begin
      state_nxt = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (rx_s == START_BIT) state_nxt = RX_START;
        RX_START: if (start_hit) state_nxt = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
        RX_DATA:  if (bit_hit && bit_cnt == LAST_BIT) state_nxt = RX_STOP;
        RX_STOP:  if (stop_hit) state_nxt = RX_IDLE;
        default:  state_nxt = RX_IDLE;
      endcase
    end
  end

  // Sample strobes: mid start bit, then centre of each data and stop bit.
  always_comb begin
    start_hit = 1'b0;
    bit_hit   = 1'b0;
    stop_hit  = 1'b0;
    if (rx_enable) begin
      case (state)
        RX_START: start_hit = (sample_cnt == HALF_M1);
        RX_DATA:  bit_hit   = (sample_cnt == FULL_M1);
        RX_STOP:  stop_hit  = (sample_cnt == FULL_M1);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
    end else if (!rx_enable) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        RX_START: begin
          if (start_hit) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_hit) begin
            sample_cnt <= '0;
            bit_cnt    <= bit_cnt + 1'b1;
            shift      <= {rx_s, shift[DATA_BITS-1:1]};
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (stop_hit) sample_cnt <= '0;
          else          sample_cnt <= sample_cnt + 1'b1;
        end
        default: begin
          sample_cnt <= '0;
          bit_cnt    <= '0;
        end
      endcase
    end
  end

  // A same-cycle unload frees the register for the byte completing now.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      rx_data      <= '0;
      rx_empty     <= 1'b1;
      rx_over_run  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else if (stop_hit && rx_s == STOP_BIT) begin
      rx_frame_err <= 1'b0;
      if (rx_empty || uld_rx_data) begin
        rx_data  <= shift;
        rx_empty <= 1'b0;
        if (uld_rx_data) rx_over_run <= 1'b0;
      end else begin
        rx_over_run <= 1'b1;
      end
    end else begin
      if (stop_hit) rx_frame_err <= 1'b1;
      if (uld_rx_data && !rx_empty) begin
        rx_empty    <= 1'b1;
        rx_over_run <= 1'b0;
      end
    end
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) rx_busy <= 1'b0;
    else       rx_busy <= (state_nxt != RX_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed scenarios plus random frames, checked every cycle against a frame-level model.
module tb_uart_rx_os;

  localparam int OSR = 16;
  // sync + idle detect (3) + half start bit + data bits + stop bit
  localparam int LAT = 3 + OSR / 2 + 8 * OSR + OSR;

  logic       txclk = 1'b0;
  logic       reset;
  logic       rx_enable;
  logic       rx_in;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_empty, rx_over_run, rx_frame_err, rx_busy;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int         done;
    logic [7:0] d;
    logic       stop;
  } frm_t;
  frm_t q[$];

  logic [7:0] m_data  = 8'h00;
  logic       m_empty = 1'b1;
  logic       m_orun  = 1'b0;
  logic       m_ferr  = 1'b0;

  uart_rx_os dut (
    .txclk        (txclk),
    .reset        (reset),
    .rx_enable    (rx_enable),
    .rx_in        (rx_in),
    .uld_rx_data  (uld_rx_data),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_over_run  (rx_over_run),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 txclk = ~txclk;

  always @(posedge txclk) cyc <= cyc + 1;

  // Holding-register model: applies each frame's outcome on the cycle it completes.
  always @(posedge txclk or posedge reset) begin
    if (reset) begin
      m_data  <= 8'h00;
      m_empty <= 1'b1;
      m_orun  <= 1'b0;
      m_ferr  <= 1'b0;
      q.delete();
    end else if (q.size() != 0 && (cyc + 1) == q[0].done) begin
      if (q[0].stop) begin
        m_ferr <= 1'b0;
        if (m_empty || uld_rx_data) begin
          m_data  <= q[0].d;
          m_empty <= 1'b0;
          if (uld_rx_data) m_orun <= 1'b0;
        end else begin
          m_orun <= 1'b1;
        end
      end else begin
        m_ferr <= 1'b1;
        if (uld_rx_data && !m_empty) begin
          m_empty <= 1'b1;
          m_orun  <= 1'b0;
        end
      end
      void'(q.pop_front());
    end else if (uld_rx_data && !m_empty) begin
      m_empty <= 1'b1;
      m_orun  <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge txclk) begin
    if (cmp_en) begin
      check("rx_data", 32'(rx_data), 32'(m_data));
      check("rx_empty", 32'(rx_empty), 32'(m_empty));
      check("rx_over_run", 32'(rx_over_run), 32'(m_orun));
      check("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));
    end
  end

  task automatic tick;
    @(posedge txclk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) tick;
  endtask

  task automatic pulse_uld;
    uld_rx_data = 1'b1;
    tick;
    uld_rx_data = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit sched);
    frm_t f;
    rx_in = 1'b0;
    if (sched) begin
      f.done = cyc + LAT;
      f.d    = d;
      f.stop = stop;
      q.push_back(f);
    end
    repeat (OSR) tick;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (OSR) tick;
    end
    rx_in = stop;
    repeat (OSR) tick;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  busy_seen;
    reset       = 1'b1;
    rx_enable   = 1'b1;
    rx_in       = 1'b1;
    uld_rx_data = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    cmp_en = 1'b1;

    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_empty", 32'(rx_empty), 32'h1);
    check("reset rx_over_run", 32'(rx_over_run), 32'h0);
    check("reset rx_frame_err", 32'(rx_frame_err), 32'h0);
    check("reset rx_busy", 32'(rx_busy), 32'h0);

    // 0xA5 with latency measurement
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        while (rx_empty && lat < 300) begin
          tick;
          lat++;
        end
      end
    join
    nchk++;
    if (lat < 154 || lat > 156) begin
      nerr++;
      $display("FAIL latency: got %0d cycles, expected 154..156", lat);
    end
    idle(10);
    check("A5 rx_data", 32'(rx_data), 32'hA5);
    check("A5 rx_empty", 32'(rx_empty), 32'h0);
    check("A5 rx_busy idle", 32'(rx_busy), 32'h0);
    pulse_uld;
    tick;
    check("A5 uld rx_empty", 32'(rx_empty), 32'h1);
    check("A5 uld rx_data held", 32'(rx_data), 32'hA5);

    // back-to-back 0x3C, 0xC3 without unload -> overrun
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(5);
    check("ovr rx_data", 32'(rx_data), 32'h3C);
    check("ovr rx_over_run", 32'(rx_over_run), 32'h1);
    check("ovr rx_empty", 32'(rx_empty), 32'h0);
    pulse_uld;
    tick;
    check("ovr uld rx_over_run", 32'(rx_over_run), 32'h0);
    check("ovr uld rx_empty", 32'(rx_empty), 32'h1);

    // bad stop bit, then a good frame clears the flag
    send_frame(8'h55, 1'b0, 1'b1);
    idle(40);
    check("ferr rx_frame_err", 32'(rx_frame_err), 32'h1);
    check("ferr rx_empty", 32'(rx_empty), 32'h1);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(5);
    check("ferr clr rx_frame_err", 32'(rx_frame_err), 32'h0);
    check("ferr clr rx_data", 32'(rx_data), 32'h12);
    pulse_uld;
    idle(5);

    // 4-cycle glitch
    busy_seen = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rx_in = 1'b1;
      tick;
      busy_seen |= rx_busy;
    end
    check("glitch busy pulsed", 32'(busy_seen), 32'h1);
    check("glitch busy cleared", 32'(rx_busy), 32'h0);
    check("glitch rx_data", 32'(rx_data), 32'h12);
    check("glitch rx_empty", 32'(rx_empty), 32'h1);
    check("glitch rx_frame_err", 32'(rx_frame_err), 32'h0);

    // reset during bit 4 of 0xFF
    rx_in = 1'b0;
    repeat (OSR) tick;
    rx_in = 1'b1;
    repeat (4 * OSR) tick;
    do_reset;
    tick;
    check("midrst rx_data", 32'(rx_data), 32'h00);
    check("midrst rx_busy", 32'(rx_busy), 32'h0);
    idle(200);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(5);
    check("midrst 81 rx_data", 32'(rx_data), 32'h81);
    check("midrst 81 flags", 32'({rx_empty, rx_over_run, rx_frame_err}), 32'h0);
    pulse_uld;
    idle(5);

    // enable dropped mid-frame; unload still works while disabled
    send_frame(8'h11, 1'b1, 1'b1);
    rx_in = 1'b0;
    repeat (4 * OSR) tick;
    rx_enable = 1'b0;
    rx_in = 1'b1;
    tick;
    check("dis rx_busy", 32'(rx_busy), 32'h0);
    pulse_uld;
    idle(20);
    check("dis uld rx_empty", 32'(rx_empty), 32'h1);
    check("dis rx_data held", 32'(rx_data), 32'h11);
    rx_enable = 1'b1;
    idle(5);
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(5);
    check("en 7E rx_data", 32'(rx_data), 32'h7E);
    check("en 7E rx_empty", 32'(rx_empty), 32'h0);
    pulse_uld;
    idle(5);

    // unload on the exact completion cycle of a new byte
    send_frame(8'h33, 1'b1, 1'b1);
    fork
      send_frame(8'h99, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) tick;
        pulse_uld;
      end
    join
    idle(5);
    check("uldhit rx_data", 32'(rx_data), 32'h99);
    check("uldhit rx_empty", 32'(rx_empty), 32'h0);
    check("uldhit rx_over_run", 32'(rx_over_run), 32'h0);
    pulse_uld;
    idle(5);

    // random frames, gaps and unloads
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       stop;
      d    = 8'($urandom);
      stop = ($urandom_range(7, 0) != 0);
      fork
        send_frame(d, stop, 1'b1);
        begin
          if ($urandom_range(1, 0) == 1) begin
            repeat ($urandom_range(158, 0)) tick;
            pulse_uld;
          end
        end
      join
      if (stop) idle($urandom_range(20, 0));
      else      idle(20 + $urandom_range(20, 0));
    end

    idle(50);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
